// File: rtl/cdb_arbiter_pkg.sv
// Shared constants and helpers for the CDB arbiter slice: default sizing and
// the producer index assignments on the common data bus.
package cdb_arbiter_pkg;

  localparam int CDB_NUM_SRC    = 3;
  localparam int CDB_SRC_ALU    = 0;
  localparam int CDB_SRC_MEM    = 1;
  localparam int CDB_SRC_MUL    = 2;
  localparam int CDB_ROB_W      = 4;
  localparam int CDB_FIFO_DEPTH = 4;

  typedef logic [31:0] cdb_value_t;

  function automatic int rr_next(input int idx, input int n);
    return (idx == n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// Producer-side and broadcast-side signals of the CDB arbiter. The master
// modport is the producer/consumer environment, the slave is the arbiter.
interface cdb_arbiter_if #(
  parameter int NUM_SRC = 3,
  parameter int ROB_W   = 4
);
  logic                     flush_input;
  logic [NUM_SRC*ROB_W-1:0] src_rob_id;
  logic [NUM_SRC*32-1:0]    src_value;
  logic [NUM_SRC-1:0]       src_almost_full;
  logic [ROB_W-1:0]         cdb_rob_id;
  logic [31:0]              cdb_value;
  logic                     overflow_err;

  modport master (
    output flush_input, src_rob_id, src_value,
    input  src_almost_full, cdb_rob_id, cdb_value, overflow_err
  );

  modport slave (
    input  flush_input, src_rob_id, src_value,
    output src_almost_full, cdb_rob_id, cdb_value, overflow_err
  );
endinterface

// File: rtl/cdb_src_fifo.sv
// Single-source result FIFO with wrap-bit pointers. A pop frees a slot in the
// same cycle, so push+pop on a full FIFO is accepted with count unchanged.
module cdb_src_fifo #(
  parameter int   DEPTH = 4,
  parameter int   W     = 36,
  localparam int  AW    = $clog2(DEPTH)
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full,
  output logic         almost_full
);

  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [AW:0]  wr_q, wr_d, rd_q, rd_d, count_d;
  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] mem_d [DEPTH];
  logic         af_q, af_d;
  logic         do_push, do_pop;

  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem_q[rd_q[AW-1:0]];
  assign almost_full = af_q;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    mem_d = mem_q;
    if (flush) begin
      wr_d = '0;
      rd_d = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_q[AW-1:0]] = din;
        wr_d = wr_q + PTR_ONE;
      end
      if (do_pop) rd_d = rd_q + PTR_ONE;
    end
    count_d = wr_d - rd_d;
    af_d    = int'(count_d) >= DEPTH - 1;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wr_q  <= '0;
      rd_q  <= '0;
      af_q  <= 1'b0;
      mem_q <= '{default: '0};
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      af_q  <= af_d;
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter sharing one registered CDB among NUM_SRC producers, with
// per-source FIFOs. Define CDB_ARB_STATS_EN to add stall/grant counters.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_SRC    = CDB_NUM_SRC,
  parameter int FIFO_DEPTH = CDB_FIFO_DEPTH,
  parameter int ROB_W      = CDB_ROB_W
) (
  input  logic               clk_in,
  input  logic               rst_in,
  cdb_arbiter_if.slave       bus
`ifdef CDB_ARB_STATS_EN
  ,
  output logic [NUM_SRC*32-1:0] stat_stall,
  output logic [31:0]           stat_grants
`endif
);

  localparam int SW = $clog2(NUM_SRC);

  logic [ROB_W-1:0] in_rob   [NUM_SRC];
  cdb_value_t       in_val   [NUM_SRC];
  logic [ROB_W-1:0] head_rob [NUM_SRC];
  cdb_value_t       head_val [NUM_SRC];
  logic [NUM_SRC-1:0] in_vld, empty, full, af, pending, push, pop, is_win;

  logic [SW-1:0]    rr_q, rr_d, win;
  logic             found;
  logic [ROB_W-1:0] cdb_rob_q, cdb_rob_d;
  cdb_value_t       cdb_val_q, cdb_val_d;
  logic             ovf_q, ovf_d;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    logic [ROB_W+31:0] dout;
    assign in_rob[i] = bus.src_rob_id[i*ROB_W +: ROB_W];
    assign in_val[i] = bus.src_value[i*32 +: 32];
    assign in_vld[i] = |in_rob[i];
    assign {head_rob[i], head_val[i]} = dout;

    cdb_src_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (ROB_W + 32)
    ) u_fifo (
      .clk_in      (clk_in),
      .rst_in      (rst_in),
      .flush       (bus.flush_input),
      .push        (push[i]),
      .pop         (pop[i]),
      .din         ({in_rob[i], in_val[i]}),
      .dout        (dout),
      .empty       (empty[i]),
      .full        (full[i]),
      .almost_full (af[i])
    );
  end

  assign pending = ~empty | in_vld;

  // Two passes give the rotated scan: sources at/above rr_q first, then wrap.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (!found && pending[i] && (SW'(i) >= rr_q)) begin
        found = 1'b1;
        win   = SW'(i);
      end
    end
    for (int i = 0; i < NUM_SRC; i++) begin
      if (!found && pending[i]) begin
        found = 1'b1;
        win   = SW'(i);
      end
    end
  end

  always_comb begin
    rr_d      = rr_q;
    cdb_rob_d = '0;
    cdb_val_d = '0;
    ovf_d     = ovf_q;
    push      = '0;
    pop       = '0;
    is_win    = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      is_win[i] = found && (win == SW'(i));
      if (is_win[i]) begin
        if (!empty[i]) begin
          pop[i]    = 1'b1;
          cdb_rob_d = head_rob[i];
          cdb_val_d = head_val[i];
        end else begin
          cdb_rob_d = in_rob[i];
          cdb_val_d = in_val[i];
        end
      end
      // A bypass winner consumes its input directly; anything else queues.
      push[i] = in_vld[i] && !(is_win[i] && empty[i]);
      if (push[i] && full[i] && !pop[i]) ovf_d = 1'b1;
    end
    if (found) rr_d = SW'(rr_next(int'(win), NUM_SRC));
    if (bus.flush_input) begin
      rr_d      = '0;
      cdb_rob_d = '0;
      cdb_val_d = '0;
      ovf_d     = ovf_q;
      push      = '0;
      pop       = '0;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      rr_q      <= '0;
      cdb_rob_q <= '0;
      cdb_val_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      rr_q      <= rr_d;
      cdb_rob_q <= cdb_rob_d;
      cdb_val_q <= cdb_val_d;
      ovf_q     <= ovf_d;
    end
  end

  assign bus.cdb_rob_id      = cdb_rob_q;
  assign bus.cdb_value       = cdb_val_q;
  assign bus.overflow_err    = ovf_q;
  assign bus.src_almost_full = af;

`ifdef CDB_ARB_STATS_EN
  logic [31:0] stall_q [NUM_SRC];
  logic [31:0] stall_d [NUM_SRC];
  logic [31:0] grant_q, grant_d;

  always_comb begin
    grant_d = grant_q;
    if ((cdb_rob_q != '0) && (grant_q != '1)) grant_d = grant_q + 32'd1;
    for (int i = 0; i < NUM_SRC; i++) begin
      stall_d[i] = stall_q[i];
      if (pending[i] && !is_win[i] && (stall_q[i] != '1)) stall_d[i] = stall_q[i] + 32'd1;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      grant_q <= '0;
      stall_q <= '{default: '0};
    end else begin
      grant_q <= grant_d;
      stall_q <= stall_d;
    end
  end

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_stat
    assign stat_stall[i*32 +: 32] = stall_q[i];
  end
  assign stat_grants = grant_q;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: a cycle-by-cycle vector table plus an
// asynchronous reset sequence, default parameters (3 sources, depth 4).
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  localparam int NS = 3;
  localparam int RW = 4;

  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  always #5 clk_in = ~clk_in;

  cdb_arbiter_if #(.NUM_SRC(NS), .ROB_W(RW)) bus ();

`ifdef CDB_ARB_STATS_EN
  logic [NS*32-1:0] stat_stall;
  logic [31:0]      stat_grants;
`endif

  cdb_arbiter #(.NUM_SRC(NS), .FIFO_DEPTH(4), .ROB_W(RW)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus)
`ifdef CDB_ARB_STATS_EN
    ,
    .stat_stall  (stat_stall),
    .stat_grants (stat_grants)
`endif
  );

  typedef struct {
    logic       fl;
    logic [3:0] r0, r1, r2;
    logic [3:0] er;
    int         es;
    logic [2:0] af;
    logic       ovf;
  } vec_t;

  vec_t vt[$];
  int total = 0;
  int bad   = 0;

  function automatic logic [31:0] mkval(input int src, input logic [3:0] rob);
    if (rob == 4'd0) return 32'd0;
    return 32'h100 * (src + 1) + {28'd0, rob};
  endfunction

  task automatic add(input logic fl, input logic [3:0] r0, input logic [3:0] r1,
                     input logic [3:0] r2, input logic [3:0] er, input int es,
                     input logic [2:0] af, input logic ovf);
    vec_t v;
    v.fl = fl; v.r0 = r0; v.r1 = r1; v.r2 = r2;
    v.er = er; v.es = es; v.af = af; v.ovf = ovf;
    vt.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic fl, input logic [3:0] r0, input logic [3:0] r1,
                       input logic [3:0] r2);
    bus.flush_input = fl;
    bus.src_rob_id  = {r2, r1, r0};
    bus.src_value   = {mkval(2, r2), mkval(1, r1), mkval(0, r0)};
  endtask

  initial begin
    // fl  r0  r1  r2 | rob src af  ovf
    add(0, 0,  0,  0,   0, 0, 3'b000, 0);  // reset state
    add(0, 3,  0,  0,   3, 0, 3'b000, 0);  // single result, latency 1
    add(0, 0,  0,  0,   0, 0, 3'b000, 0);
    add(1, 0,  0,  0,   0, 0, 3'b000, 0);  // return rr to 0
    add(0, 1,  2,  3,   1, 0, 3'b000, 0);  // three at once
    add(0, 0,  0,  0,   2, 1, 3'b000, 0);
    add(0, 0,  0,  0,   3, 2, 3'b000, 0);
    add(0, 0,  0,  0,   0, 0, 3'b000, 0);
    add(0, 1,  4, 11,   1, 0, 3'b000, 0);  // src1 stream under contention
    add(0, 2,  5, 12,   4, 1, 3'b000, 0);
    add(0, 3,  6, 13,  11, 2, 3'b000, 0);
    add(0, 0,  7,  0,   2, 0, 3'b010, 0);
    add(0, 0,  8,  0,   5, 1, 3'b010, 0);
    add(0, 0,  9,  0,  12, 2, 3'b010, 0);
    add(0, 0, 10,  0,   3, 0, 3'b010, 1);  // push into full FIFO, dropped
    add(0, 0,  0,  0,   6, 1, 3'b010, 1);
    add(0, 0,  0,  0,  13, 2, 3'b010, 1);
    add(0, 0,  0,  0,   7, 1, 3'b000, 1);
    add(0, 0,  0,  0,   8, 1, 3'b000, 1);
    add(0, 0,  0,  0,   9, 1, 3'b000, 1);
    add(0, 0,  0,  0,   0, 0, 3'b000, 1);
    add(0, 7,  0,  0,   7, 0, 3'b000, 1);  // wrap from rr=2 to src0
    add(0, 1,  4,  0,   4, 1, 3'b000, 1);  // queue two in src0
    add(0, 3,  0,  2,   2, 2, 3'b000, 1);
    add(1, 5,  6,  0,   0, 0, 3'b000, 1);  // flush drops queue and inputs
    add(0, 8,  9,  0,   8, 0, 3'b000, 1);
    add(0, 0,  0,  0,   9, 1, 3'b000, 1);
    add(0, 0,  0,  0,   0, 0, 3'b000, 1);

    drive(0, 0, 0, 0);
    repeat (2) @(posedge clk_in);
    #1 rst_in = 1'b0;

    for (int i = 0; i < vt.size(); i++) begin
      drive(vt[i].fl, vt[i].r0, vt[i].r1, vt[i].r2);
      @(posedge clk_in);
      #1;
      chk($sformatf("v%0d cdb_rob", i), 32'(bus.cdb_rob_id), 32'(vt[i].er));
      chk($sformatf("v%0d cdb_val", i), bus.cdb_value,
          (vt[i].er == 4'd0) ? 32'd0 : mkval(vt[i].es, vt[i].er));
      chk($sformatf("v%0d almost_full", i), 32'(bus.src_almost_full), 32'(vt[i].af));
      chk($sformatf("v%0d overflow", i), 32'(bus.overflow_err), 32'(vt[i].ovf));
    end

    // Asynchronous reset in mid-cycle with a result on the bus.
    drive(0, 0, 0, 5);
    @(posedge clk_in);
    #1;
    drive(0, 0, 0, 0);
    chk("pre_rst cdb_rob", 32'(bus.cdb_rob_id), 32'd5);
    #2 rst_in = 1'b1;
    #1;
    chk("async_rst cdb_rob", 32'(bus.cdb_rob_id), 32'd0);
    chk("async_rst cdb_val", bus.cdb_value, 32'd0);
    chk("async_rst overflow", 32'(bus.overflow_err), 32'd0);
    #2 rst_in = 1'b0;

    // After reset rr points at src0 again.
    @(posedge clk_in);
    #1;
    drive(0, 7, 6, 0);
    @(posedge clk_in);
    #1;
    drive(0, 0, 0, 0);
    chk("post_rst cdb_rob", 32'(bus.cdb_rob_id), 32'd7);
    chk("post_rst cdb_val", bus.cdb_value, mkval(0, 4'd7));
    @(posedge clk_in);
    #1;
    chk("post_rst second", 32'(bus.cdb_rob_id), 32'd6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
